time_set_editor: RTL and testbench

- Writer side of the 10-bit start-time word {hour[3:0], minute[5:0]} consumed by the timer/stopwatch/clock top level.
- Lets the user set hour and minute from three raw active-low pushbuttons: a field-select FSM, per-button debounce, wrap-around arithmetic and an idle timeout.
- Drives BCD digits, with a blink mask on the field being edited, for the existing seven-segment decoders.
- Publishes a new start word only when the user commits it.

---
 rtl/time_set_editor.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_time_set_editor.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_editor.sv
// -----------------------------------------------------------------------------
// time_set_editor
//
// User editor for the 10-bit start-time word {hour[3:0], minute[5:0]}.
// Three raw active-low pushbuttons are synchronised and debounced. A
// field-select FSM (IDLE -> EDIT_HOUR -> EDIT_MIN -> COMMIT) steps the hour
// (1..12) and the minute (0..59) with wrap-around. An idle timeout abandons an
// unfinished edit. A new start word is published only when the user commits.
//
// Optional feature macro: AUTO_REPEAT_EN
//   When this macro is defined, holding inc or dec in an edit state produces
//   repeated steps. The first repeat comes after REPEAT_DELAY cycles and the
//   following ones every REPEAT_PERIOD cycles.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   btn_next   in   raw button (active-low): advance field / commit
//   btn_inc    in   raw button (active-low): increment selected field
//   btn_dec    in   raw button (active-low): decrement selected field
//   start_num  out  committed start word {hour, minute}
//   commit     out  one-cycle pulse when start_num is updated
//   editing    out  high while in EDIT_HOUR or EDIT_MIN
//   hour_tens, hour_ones, min_tens, min_ones  out  BCD of the working value
//   blank_mask out  per-digit blank {hour_tens, hour_ones, min_tens, min_ones}
// -----------------------------------------------------------------------------
module time_set_editor #(
  parameter int DEBOUNCE_CYCLES = 5000000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int TIMEOUT_CYCLES  = 500000000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [9:0] start_num,
  output logic       commit,
  output logic       editing,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] blank_mask
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  // Converts a value in 0..59 into {tens, ones} BCD.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] base;
    if (v >= 6'd50) begin
      tens = 4'd5; base = 6'd50;
    end else if (v >= 6'd40) begin
      tens = 4'd4; base = 6'd40;
    end else if (v >= 6'd30) begin
      tens = 4'd3; base = 6'd30;
    end else if (v >= 6'd20) begin
      tens = 4'd2; base = 6'd20;
    end else if (v >= 6'd10) begin
      tens = 4'd1; base = 6'd10;
    end else begin
      tens = 4'd0; base = 6'd0;
    end
    to_bcd = {tens, 4'(v - base)};
  endfunction

  // Button bit order: [0]=next, [1]=inc, [2]=dec. A bit value of 1 means released.
  logic [2:0]    raw_s;
  logic [2:0]    sync1_r, sync2_r, deb_r, press_r;
  logic [DW-1:0] deb_cnt_r [3];

  assign raw_s = {btn_dec, btn_inc, btn_next};

  // Synchronise each button, debounce it, and emit a pulse on each accepted press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      deb_r   <= 3'b111;
      press_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb_r[i]     <= sync2_r[i];
            deb_cnt_r[i] <= '0;
            // A press is a debounced high-to-low transition. A release gives no pulse.
            press_r[i]   <= ~sync2_r[i];
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
            press_r[i]   <= 1'b0;
          end
        end else begin
          deb_cnt_r[i] <= '0;
          press_r[i]   <= 1'b0;
        end
      end
    end
  end

  state_t        state_r, state_next;
  logic [3:0]    hour_r, hour_next;
  logic [5:0]    min_r, min_next;
  logic [9:0]    start_r, start_next;
  logic [TW-1:0] to_cnt_r, to_cnt_next;
  logic [BW-1:0] blink_cnt_r, blink_cnt_next;
  logic          blink_off_r, blink_off_next;
  logic          commit_r, editing_r;
  logic [3:0]    blank_r, blank_next;
  logic [7:0]    hour_bcd_r, min_bcd_r;

  logic ev_next_s, ev_inc_s, ev_dec_s;
  logic any_ev_s, step_inc_s, step_dec_s, step_taken_s;
  logic in_edit_s, next_in_edit_s, timeout_s;

  assign ev_next_s = press_r[0];

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt_r;
  logic          rep_armed_r, rep_pulse_r, hold_s;

  // Exactly one of inc or dec is held, and the FSM is in an edit state.
  assign hold_s = (deb_r[1] ^ deb_r[2]) && ((state_r == EDIT_HOUR) || (state_r == EDIT_MIN));

  // Auto-repeat timer: first step after REPEAT_DELAY, then one every REPEAT_PERIOD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt_r   <= '0;
      rep_armed_r <= 1'b0;
      rep_pulse_r <= 1'b0;
    end else if (!hold_s) begin
      rep_cnt_r   <= '0;
      rep_armed_r <= 1'b0;
      rep_pulse_r <= 1'b0;
    end else if (!rep_armed_r) begin
      if (rep_cnt_r == RW'(REPEAT_DELAY - 1)) begin
        rep_cnt_r   <= '0;
        rep_armed_r <= 1'b1;
        rep_pulse_r <= 1'b1;
      end else begin
        rep_cnt_r   <= rep_cnt_r + RW'(1);
        rep_pulse_r <= 1'b0;
      end
    end else begin
      if (rep_cnt_r == RW'(REPEAT_PERIOD - 1)) begin
        rep_cnt_r   <= '0;
        rep_pulse_r <= 1'b1;
      end else begin
        rep_cnt_r   <= rep_cnt_r + RW'(1);
        rep_pulse_r <= 1'b0;
      end
    end
  end

  assign ev_inc_s = press_r[1] | (rep_pulse_r & ~deb_r[1]);
  assign ev_dec_s = press_r[2] | (rep_pulse_r & ~deb_r[2]);
`else
  assign ev_inc_s = press_r[1];
  assign ev_dec_s = press_r[2];
`endif

  // FSM next state, field arithmetic, and next values for the timeout, blink and display registers.
  always_comb begin
    any_ev_s       = ev_next_s | ev_inc_s | ev_dec_s;
    // next takes priority over inc/dec; inc and dec together cancel each other.
    step_inc_s     = ev_inc_s & ~ev_dec_s & ~ev_next_s;
    step_dec_s     = ev_dec_s & ~ev_inc_s & ~ev_next_s;
    in_edit_s      = (state_r == EDIT_HOUR) || (state_r == EDIT_MIN);
    timeout_s      = in_edit_s && !any_ev_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
    state_next     = state_r;
    hour_next      = hour_r;
    min_next       = min_r;
    step_taken_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ev_next_s) begin
          state_next = EDIT_HOUR;
          hour_next  = start_r[9:6];
          min_next   = start_r[5:0];
        end else begin
          state_next = IDLE;
        end
      end
      EDIT_HOUR: begin
        if (timeout_s) begin
          state_next = IDLE;
          hour_next  = start_r[9:6];
          min_next   = start_r[5:0];
        end else if (ev_next_s) begin
          state_next = EDIT_MIN;
        end else if (step_inc_s) begin
          hour_next    = (hour_r == 4'd12) ? 4'd1 : hour_r + 4'd1;
          step_taken_s = 1'b1;
        end else if (step_dec_s) begin
          hour_next    = (hour_r <= 4'd1) ? 4'd12 : hour_r - 4'd1;
          step_taken_s = 1'b1;
        end else begin
          state_next = EDIT_HOUR;
        end
      end
      EDIT_MIN: begin
        if (timeout_s) begin
          state_next = IDLE;
          hour_next  = start_r[9:6];
          min_next   = start_r[5:0];
        end else if (ev_next_s) begin
          state_next = COMMIT;
        end else if (step_inc_s) begin
          min_next     = (min_r >= 6'd59) ? 6'd0 : min_r + 6'd1;
          step_taken_s = 1'b1;
        end else if (step_dec_s) begin
          min_next     = (min_r == 6'd0) ? 6'd59 : min_r - 6'd1;
          step_taken_s = 1'b1;
        end else begin
          state_next = EDIT_MIN;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    next_in_edit_s = (state_next == EDIT_HOUR) || (state_next == EDIT_MIN);

    // Publish the word on entry to COMMIT so that commit and start_num change together.
    if (state_next == COMMIT) begin
      start_next = {hour_r, min_r};
    end else begin
      start_next = start_r;
    end

    // The timeout counter runs only while the FSM stays in one edit state with no events.
    if (!next_in_edit_s || any_ev_s || (state_next != state_r)) begin
      to_cnt_next = '0;
    end else begin
      to_cnt_next = to_cnt_r + TW'(1);
    end

    // Restart the blink in the visible phase so that a change shows immediately.
    if ((state_next != state_r) || step_taken_s) begin
      blink_cnt_next = '0;
      blink_off_next = 1'b0;
    end else if (blink_cnt_r == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_next = '0;
      blink_off_next = ~blink_off_r;
    end else begin
      blink_cnt_next = blink_cnt_r + BW'(1);
      blink_off_next = blink_off_r;
    end

    case (state_next)
      EDIT_HOUR: blank_next = blink_off_next ? 4'b1100 : 4'b0000;
      EDIT_MIN:  blank_next = blink_off_next ? 4'b0011 : 4'b0000;
      default:   blank_next = 4'b0000;
    endcase
  end

  // State, working values, committed word, counters, and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      hour_r      <= 4'd12;
      min_r       <= 6'd0;
      start_r     <= 10'd768;
      to_cnt_r    <= '0;
      blink_cnt_r <= '0;
      blink_off_r <= 1'b0;
      commit_r    <= 1'b0;
      editing_r   <= 1'b0;
      blank_r     <= 4'b0000;
      hour_bcd_r  <= 8'h12;
      min_bcd_r   <= 8'h00;
    end else begin
      state_r     <= state_next;
      hour_r      <= hour_next;
      min_r       <= min_next;
      start_r     <= start_next;
      to_cnt_r    <= to_cnt_next;
      blink_cnt_r <= blink_cnt_next;
      blink_off_r <= blink_off_next;
      commit_r    <= (state_next == COMMIT);
      editing_r   <= next_in_edit_s;
      blank_r     <= blank_next;
      hour_bcd_r  <= to_bcd({2'b00, hour_next});
      min_bcd_r   <= to_bcd(min_next);
    end
  end

  assign start_num  = start_r;
  assign commit     = commit_r;
  assign editing    = editing_r;
  assign hour_tens  = hour_bcd_r[7:4];
  assign hour_ones  = hour_bcd_r[3:0];
  assign min_tens   = min_bcd_r[7:4];
  assign min_ones   = min_bcd_r[3:0];
  assign blank_mask = blank_r;

endmodule

// File: tb/tb_time_set_editor.sv
// -----------------------------------------------------------------------------
// tb_time_set_editor
// Directed self-checking bench for time_set_editor. It uses
// DEBOUNCE_CYCLES=4, BLINK_CYCLES=8 and TIMEOUT_CYCLES=200.
// -----------------------------------------------------------------------------
module tb_time_set_editor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_next = 1'b1;
  logic       btn_inc = 1'b1;
  logic       btn_dec = 1'b1;
  logic [9:0] start_num;
  logic       commit;
  logic       editing;
  logic [3:0] hour_tens, hour_ones, min_tens, min_ones, blank_mask;

  int tests_run = 0;
  int tests_failed = 0;
  int commit_cnt = 0;

  logic [15:0] digits;
  assign digits = {hour_tens, hour_ones, min_tens, min_ones};

  always #5 clk = ~clk;

  time_set_editor #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_CYCLES(8),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_next(btn_next),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .start_num(start_num),
    .commit(commit),
    .editing(editing),
    .hour_tens(hour_tens),
    .hour_ones(hour_ones),
    .min_tens(min_tens),
    .min_ones(min_ones),
    .blank_mask(blank_mask)
  );

  // Stimulus only: hold the selected buttons (m = {next, inc, dec}) low for
  // 8 cycles, then release them for 10 cycles. Count the cycles with commit high.
  task automatic press(input logic [2:0] m);
    @(negedge clk);
    {btn_next, btn_inc, btn_dec} = ~m;
    repeat (8) begin
      @(negedge clk);
      if (commit === 1'b1) commit_cnt++;
    end
    {btn_next, btn_inc, btn_dec} = 3'b111;
    repeat (10) begin
      @(negedge clk);
      if (commit === 1'b1) commit_cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (start_num !== 10'd768) begin
      tests_failed++; $display("FAIL reset_start_num got %0d want 768", start_num);
    end
    tests_run++;
    if (digits !== 16'h1200) begin
      tests_failed++; $display("FAIL reset_digits got %h want 1200", digits);
    end
    tests_run++;
    if (editing !== 1'b0) begin
      tests_failed++; $display("FAIL reset_editing got %b want 0", editing);
    end
    tests_run++;
    if (blank_mask !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_blank got %b want 0000", blank_mask);
    end
    tests_run++;
    if (commit !== 1'b0) begin
      tests_failed++; $display("FAIL reset_commit got %b want 0", commit);
    end
  endtask

  task automatic test_debounce_next;
    logic [3:0] mask_or;
    @(negedge clk); btn_next = 1'b0;
    @(negedge clk);
    @(negedge clk); btn_next = 1'b1;
    @(negedge clk); btn_next = 1'b0;   // the stable low starts here
    repeat (6) @(negedge clk);
    tests_run++;
    if (editing !== 1'b0) begin
      tests_failed++; $display("FAIL debounce_early got editing=%b want 0", editing);
    end
    @(negedge clk);
    tests_run++;
    if (editing !== 1'b1) begin
      tests_failed++; $display("FAIL debounce_latency got editing=%b want 1", editing);
    end
    repeat (3) @(negedge clk);
    btn_next = 1'b1;
    repeat (10) @(negedge clk);
    // Only EDIT_HOUR blanking may appear. 0011 would mean a second event was taken.
    mask_or = 4'b0000;
    repeat (20) begin
      @(negedge clk);
      mask_or = mask_or | blank_mask;
    end
    tests_run++;
    if (mask_or !== 4'b1100) begin
      tests_failed++; $display("FAIL blink_hour got %b want 1100", mask_or);
    end
  endtask

  task automatic test_hour_wrap;
    press(3'b010);   // inc: 12 -> 1
    tests_run++;
    if (digits !== 16'h0100) begin
      tests_failed++; $display("FAIL hour_inc_wrap got %h want 0100", digits);
    end
    commit_cnt = 0;
    press(3'b100);   // to EDIT_MIN
    press(3'b100);   // commit hour 1
    tests_run++;
    if (commit_cnt != 1) begin
      tests_failed++; $display("FAIL commit1_pulse got %0d cycles want 1", commit_cnt);
    end
    tests_run++;
    if (start_num !== 10'd64) begin
      tests_failed++; $display("FAIL commit1_start got %0d want 64", start_num);
    end
    press(3'b100);   // IDLE -> EDIT_HOUR, reload hour 1
    press(3'b001);   // 1 -> 12
    press(3'b001);   // 12 -> 11
    tests_run++;
    if (digits !== 16'h1100) begin
      tests_failed++; $display("FAIL hour_dec_wrap got %h want 1100", digits);
    end
  endtask

  task automatic test_minute_wrap;
    press(3'b100);   // to EDIT_MIN
    press(3'b001);   // 0 -> 59
    press(3'b001);   // 59 -> 58
    tests_run++;
    if (digits !== 16'h1158) begin
      tests_failed++; $display("FAIL min_dec_wrap got %h want 1158", digits);
    end
    press(3'b010);   // 58 -> 59
    press(3'b010);   // 59 -> 0 with no carry into the hour
    tests_run++;
    if (digits !== 16'h1100) begin
      tests_failed++; $display("FAIL min_inc_wrap got %h want 1100", digits);
    end
    commit_cnt = 0;
    press(3'b100);   // commit
    tests_run++;
    if (commit_cnt != 1) begin
      tests_failed++; $display("FAIL commit2_pulse got %0d cycles want 1", commit_cnt);
    end
    tests_run++;
    if (start_num !== 10'd704) begin
      tests_failed++; $display("FAIL commit2_start got %0d want 704", start_num);
    end
    tests_run++;
    if (editing !== 1'b0) begin
      tests_failed++; $display("FAIL commit2_idle got editing=%b want 0", editing);
    end
  endtask

  task automatic test_timeout;
    commit_cnt = 0;
    press(3'b100);
    press(3'b100);   // EDIT_MIN
    press(3'b010);   // minute 1
    tests_run++;
    if (digits !== 16'h1101 || editing !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_pre got digits=%h editing=%b want 1101/1", digits, editing);
    end
    repeat (200) begin
      @(negedge clk);
      if (commit === 1'b1) commit_cnt++;
    end
    tests_run++;
    if (editing !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_idle got editing=%b want 0", editing);
    end
    tests_run++;
    if (commit_cnt != 0) begin
      tests_failed++; $display("FAIL timeout_commit got %0d pulses want 0", commit_cnt);
    end
    tests_run++;
    if (start_num !== 10'd704) begin
      tests_failed++; $display("FAIL timeout_start got %0d want 704", start_num);
    end
    tests_run++;
    if (digits !== 16'h1100) begin
      tests_failed++; $display("FAIL timeout_digits got %h want 1100", digits);
    end
  endtask

  task automatic test_simultaneous;
    logic [3:0] mask_or;
    press(3'b100);   // EDIT_HOUR, hour 11
    press(3'b110);   // next and inc together: next wins
    tests_run++;
    if (digits !== 16'h1100) begin
      tests_failed++; $display("FAIL next_inc_hour got %h want 1100", digits);
    end
    mask_or = 4'b0000;
    repeat (20) begin
      @(negedge clk);
      mask_or = mask_or | blank_mask;
    end
    tests_run++;
    if (mask_or !== 4'b0011) begin
      tests_failed++; $display("FAIL next_inc_state got blank %b want 0011", mask_or);
    end
    press(3'b011);   // inc and dec together: no change
    tests_run++;
    if (digits !== 16'h1100 || editing !== 1'b1) begin
      tests_failed++;
      $display("FAIL inc_dec_cancel got digits=%h editing=%b want 1100/1", digits, editing);
    end
  endtask

  task automatic test_reset_mid_edit;
    press(3'b010);   // minute 1 while still in EDIT_MIN
    tests_run++;
    if (digits !== 16'h1101) begin
      tests_failed++; $display("FAIL mid_edit_pre got %h want 1101", digits);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (start_num !== 10'd768 || editing !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_edit_reset got start=%0d editing=%b want 768/0", start_num, editing);
    end
    tests_run++;
    if (digits !== 16'h1200) begin
      tests_failed++; $display("FAIL mid_edit_digits got %h want 1200", digits);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (start_num !== 10'd768) begin
      tests_failed++; $display("FAIL post_reset_start got %0d want 768", start_num);
    end
  endtask

  initial begin
    test_reset();
    test_debounce_next();
    test_hour_wrap();
    test_minute_wrap();
    test_timeout();
    test_simultaneous();
    test_reset_mid_edit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
